mips_instr_encoder: RTL and testbench

//  Inverse of the opcode decoder: turns a symbolic instruction request (mnemonic + fields)

---
 rtl/mips_instr_encoder.sv | 132 +++++++++++++
 tb/tb_mips_instr_encoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_instr_encoder.sv
// Builds 32-bit MIPS words from symbolic requests and streams them, with word addresses,
// to an instruction-memory loader through valid/ready handshakes on both sides.
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [4:0]        Mnem,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [4:0]        Shamt,
    input  logic [15:0]       Imm,
    input  logic [25:0]       Target,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] Addr,
    output logic [ADDR_W:0]   Count,
    output logic              Illegal,
    output logic              Full
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FULL = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    logic [1:0]        stateReg;
    logic [ADDR_W-1:0] counterReg;
    logic [ADDR_W:0]   countReg;
    logic              illegalReg;
    logic              outValidReg;
    logic [31:0]       instrReg;
    logic [ADDR_W-1:0] addrReg;

    logic [31:0] encWord;
    logic        encLegal;
    logic        accept;

    function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Shifts take their amount from Shamt and ignore Rs; all other R-types zero the shamt field.
    always_comb begin
        encWord  = '0;
        encLegal = 1'b1;
        case (Mnem)
            5'd0:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h20);
            5'd1:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h21);
            5'd2:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h22);
            5'd3:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h23);
            5'd4:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h24);
            5'd5:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h25);
            5'd6:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h26);
            5'd7:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h27);
            5'd8:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h2A);
            5'd9:  encWord = rType(Rs, Rt, Rd, 5'd0, 6'h2B);
            5'd10: encWord = rType(5'd0, Rt, Rd, Shamt, 6'h00);
            5'd11: encWord = rType(5'd0, Rt, Rd, Shamt, 6'h02);
            5'd12: encWord = rType(5'd0, Rt, Rd, Shamt, 6'h03);
            5'd13: encWord = iType(6'h23, Rs, Rt, Imm);
            5'd14: encWord = iType(6'h2B, Rs, Rt, Imm);
            5'd15: encWord = iType(6'h04, Rs, Rt, Imm);
            5'd16: encWord = {6'h02, Target};
            5'd17: encWord = iType(6'h0D, Rs, Rt, Imm);
            5'd18: encWord = iType(6'h08, Rs, Rt, Imm);
            5'd19: encWord = iType(6'h09, Rs, Rt, Imm);
            5'd20: encWord = iType(6'h0C, Rs, Rt, Imm);
            5'd21: encWord = iType(6'h0F, 5'd0, Rt, Imm);
            5'd22: encWord = iType(6'h0A, Rs, Rt, Imm);
            5'd23: encWord = iType(6'h0B, Rs, Rt, Imm);
            5'd24: encWord = iType(6'h0E, Rs, Rt, Imm);
            default: encLegal = 1'b0;
        endcase
    end

    assign ReqReady = (stateReg == RUN) && !Start && (!outValidReg || OutReady);
    assign accept   = ReqValid && ReqReady;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            stateReg    <= IDLE;
            counterReg  <= '0;
            countReg    <= '0;
            illegalReg  <= 1'b0;
            outValidReg <= 1'b0;
            instrReg    <= '0;
            addrReg     <= '0;
        end else if (Start) begin
            stateReg    <= RUN;
            counterReg  <= '0;
            countReg    <= '0;
            illegalReg  <= 1'b0;
            outValidReg <= 1'b0;
        end else begin
            // A drain is overridden below when a legal word lands in the same cycle.
            if (outValidReg && OutReady)
                outValidReg <= 1'b0;
            if (accept && encLegal) begin
                instrReg    <= encWord;
                addrReg     <= counterReg;
                outValidReg <= 1'b1;
                counterReg  <= counterReg + 1'b1;
                countReg    <= countReg + 1'b1;
                if (counterReg == LAST_ADDR)
                    stateReg <= FULL;
            end else if (accept) begin
                illegalReg <= 1'b1;
            end
        end
    end

    assign OutValid = outValidReg;
    assign Instr    = instrReg;
    assign Addr     = addrReg;
    assign Count    = countReg;
    assign Illegal  = illegalReg;
    assign Full     = (stateReg == FULL);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Scoreboard bench for mips_instr_encoder on a 4-word program: the driver queues expected
// words on acceptance and a monitor compares every word the consumer takes.
module tb_mips_instr_encoder;
    localparam int AW = 2;

    logic          CLK = 1'b0;
    logic          Reset, Start, ReqValid, OutReady;
    logic          ReqReady, OutValid, Illegal, Full;
    logic [4:0]    Mnem, Rs, Rt, Rd, Shamt;
    logic [15:0]   Imm;
    logic [25:0]   Target;
    logic [31:0]   Instr;
    logic [AW-1:0] Addr;
    logic [AW:0]   Count;

    typedef struct packed {
        logic [31:0]   instr;
        logic [AW-1:0] addr;
        logic [AW:0]   count;
    } exp_t;

    exp_t sb[$];
    int compared   = 0;
    int mismatched = 0;
    int expAddr    = 0;
    int expCount   = 0;

    mips_instr_encoder #(.ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .Mnem(Mnem), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Imm(Imm), .Target(Target),
        .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr), .Addr(Addr),
        .Count(Count), .Illegal(Illegal), .Full(Full)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: a word is taken when OutValid & OutReady hold before the rising edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (OutValid === 1'b1 && OutReady === 1'b1) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got Instr=%h Addr=%0d, none expected", Instr, Addr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("word.Instr", Instr, e.instr);
                    chk("word.Addr", 32'(Addr), 32'(e.addr));
                    chk("word.Count", 32'(Count), 32'(e.count));
                end
            end
        end
    end

    task automatic send(input logic [4:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tg, input logic [31:0] exp, input bit legal);
        bit ok = 1'b0;
        Mnem = mn; Rs = rs; Rt = rt; Rd = rd; Shamt = sh; Imm = imm; Target = tg;
        ReqValid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge CLK);
            ok = ReqReady;
            @(posedge CLK);
            #1;
        end
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: mnem %0d not accepted, required accept within 50 cycles", mn);
        end else begin
            $display("sent mnem=%0d expected %h legal=%0d", mn, exp, legal);
            if (legal) begin
                expCount++;
                sb.push_back('{exp, AW'(expAddr), (AW+1)'(expCount)});
                expAddr++;
            end
        end
        ReqValid = 1'b0;
    endtask

    task automatic pulseStart();
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        expAddr  = 0;
        expCount = 0;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; ReqValid = 1'b0; OutReady = 1'b1;
        Mnem = '0; Rs = '0; Rt = '0; Rd = '0; Shamt = '0; Imm = '0; Target = '0;
        repeat (2) @(posedge CLK);
        #1;
        Reset = 1'b0;
        chk("reset.OutValid", 32'(OutValid), 0);
        chk("reset.Instr", Instr, 0);
        chk("reset.Count", 32'(Count), 0);
        chk("reset.Illegal", 32'(Illegal), 0);
        chk("reset.Full", 32'(Full), 0);
        chk("reset.ReqReady_idle", 32'(ReqReady), 0);

        // Basic encodings, forced rs on LUI, jump format.
        pulseStart();
        send(5'd0,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'h0, 32'h00221820, 1'b1);
        send(5'd21, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0, 32'h3C041234, 1'b1);
        send(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000010, 32'h08000010, 1'b1);
        repeat (2) @(posedge CLK);
        #1;

        // Back-pressure: word held, ReqReady low, then a streaming burst to FULL.
        pulseStart();
        OutReady = 1'b0;
        send(5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 26'h0, 32'h00853022, 1'b1);
        Mnem = 5'd10; ReqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall.ReqReady", 32'(ReqReady), 0);
            chk("stall.Instr", Instr, 32'h00853022);
            chk("stall.OutValid", 32'(OutValid), 1);
        end
        @(posedge CLK);
        #1;
        OutReady = 1'b1;
        send(5'd10, 5'd9,  5'd2, 5'd8, 5'd4, 16'h0000, 26'h0, 32'h00024100, 1'b1);
        send(5'd13, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0, 32'h8FA80004, 1'b1);
        send(5'd15, 5'd1,  5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF, 1'b1);
        chk("full.Full", 32'(Full), 1);
        chk("full.ReqReady", 32'(ReqReady), 0);
        chk("full.Count", 32'(Count), 4);
        Mnem = 5'd14; Rs = 5'd3; Rt = 5'd4; Imm = 16'h0010; ReqValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("full.held_ReqReady", 32'(ReqReady), 0);
        end
        chk("full.drained_OutValid", 32'(OutValid), 0);
        @(posedge CLK);
        #1;
        pulseStart();
        chk("restart.Count", 32'(Count), 0);
        chk("restart.Full", 32'(Full), 0);
        send(5'd14, 5'd3, 5'd4, 5'd0, 5'd0, 16'h0010, 26'h0, 32'hAC640010, 1'b1);

        // Illegal mnemonic is consumed without producing a word.
        send(5'd27, 5'd1, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("illegal.Illegal", 32'(Illegal), 1);
        chk("illegal.Count", 32'(Count), 1);
        chk("illegal.OutValid", 32'(OutValid), 0);
        send(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFF00, 26'h0, 32'h3422FF00, 1'b1);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        pulseStart();
        chk("start.Illegal", 32'(Illegal), 0);
        chk("start.Count", 32'(Count), 0);

        // Reset while a word is pending.
        OutReady = 1'b0;
        send(5'd7, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221827, 1'b1);
        @(negedge CLK);
        chk("pending.OutValid", 32'(OutValid), 1);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        Reset = 1'b0;
        sb.delete();
        chk("rst.OutValid", 32'(OutValid), 0);
        chk("rst.ReqReady", 32'(ReqReady), 0);
        chk("rst.Instr", Instr, 0);
        chk("rst.Addr", 32'(Addr), 0);
        chk("rst.Count", 32'(Count), 0);
        OutReady = 1'b1;

        pulseStart();
        send(5'd12, 5'd9, 5'd2, 5'd3, 5'd31, 16'h0000, 26'h0, 32'h00021FC3, 1'b1);
        send(5'd19, 5'd0, 5'd5, 5'd0, 5'd0,  16'h0007, 26'h0, 32'h24050007, 1'b1);
        send(5'd9,  5'd6, 5'd7, 5'd8, 5'd3,  16'h0000, 26'h0, 32'h00C7402B, 1'b1);
        send(5'd24, 5'd2, 5'd3, 5'd0, 5'd0,  16'hABCD, 26'h0, 32'h3843ABCD, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        chk("end.Full", 32'(Full), 1);
        chk("end.Count", 32'(Count), 4);
        chk("end.scoreboard_empty", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
